button_event_gen: RTL and testbench

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/button_event_gen.sv | 100 ++++++++++
 tb/tb_button_event_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - per-button press/release/held/auto-repeat event generator
// Auto-repeat logic is compiled in only when BUTTON_EVENT_AUTOREPEAT_EN is defined.
module button_event_gen #(
  parameter int BUTTON_COUNT       = 5,
  parameter int HOLD_COUNTER_WIDTH = 24
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [BUTTON_COUNT-1:0]       i_buttons,
  input  logic [HOLD_COUNTER_WIDTH-1:0] i_hold_delay,
  input  logic [HOLD_COUNTER_WIDTH-1:0] i_repeat_period,
  output logic [BUTTON_COUNT-1:0]       o_press,
  output logic [BUTTON_COUNT-1:0]       o_release,
  output logic [BUTTON_COUNT-1:0]       o_held,
  output logic [BUTTON_COUNT-1:0]       o_repeat,
  output logic                          o_any_press
);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  localparam logic [HOLD_COUNTER_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [HOLD_COUNTER_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [HOLD_COUNTER_WIDTH-1:0] CNT_ONE  = {{(HOLD_COUNTER_WIDTH-1){1'b0}}, 1'b1};

  state_t                        state [BUTTON_COUNT];
  logic [HOLD_COUNTER_WIDTH-1:0] cnt   [BUTTON_COUNT];
  logic [BUTTON_COUNT-1:0]       prev;

`ifndef BUTTON_EVENT_AUTOREPEAT_EN
  logic unused_repeat_period;
  assign unused_repeat_period = ^i_repeat_period;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      prev        <= '0;
      o_press     <= '0;
      o_release   <= '0;
      o_held      <= '0;
      o_repeat    <= '0;
      o_any_press <= 1'b0;
      for (int n = 0; n < BUTTON_COUNT; n++) begin
        state[n] <= IDLE;
        cnt[n]   <= CNT_ZERO;
      end
    end else begin
      prev        <= i_buttons;
      o_press     <= i_buttons & ~prev;
      o_release   <= ~i_buttons & prev;
      o_any_press <= |o_press;
      for (int n = 0; n < BUTTON_COUNT; n++) begin
        o_repeat[n] <= 1'b0;
        // A falling edge wins over any terminal count reached on the same cycle.
        if (prev[n] && !i_buttons[n]) begin
          state[n]  <= IDLE;
          cnt[n]    <= CNT_ZERO;
          o_held[n] <= 1'b0;
        end else begin
          case (state[n])
            IDLE: begin
              if (!prev[n] && i_buttons[n]) begin
                state[n] <= PRESSED;
                cnt[n]   <= CNT_ZERO;
              end
            end
            PRESSED: begin
              if (i_hold_delay != CNT_ZERO && (cnt[n] + CNT_ONE) == i_hold_delay) begin
                state[n]  <= HELD;
                cnt[n]    <= CNT_ZERO;
                o_held[n] <= 1'b1;
              end else if (cnt[n] != CNT_MAX) begin
                cnt[n] <= cnt[n] + CNT_ONE;
              end
            end
            HELD: begin
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
              if (i_repeat_period != CNT_ZERO && (cnt[n] + CNT_ONE) == i_repeat_period) begin
                o_repeat[n] <= 1'b1;
                cnt[n]      <= CNT_ZERO;
              end else if (cnt[n] != CNT_MAX) begin
                cnt[n] <= cnt[n] + CNT_ONE;
              end
`else
              if (cnt[n] != CNT_MAX) begin
                cnt[n] <= cnt[n] + CNT_ONE;
              end
`endif
            end
            default: begin
              state[n]  <= IDLE;
              cnt[n]    <= CNT_ZERO;
              o_held[n] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - scoreboard bench for button_event_gen
module tb_button_event_gen;

  localparam int BC = 5;
  localparam int W  = 8;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BC-1:0] btn = '0;
  logic [W-1:0]  hold = '0;
  logic [W-1:0]  period = '0;
  logic [BC-1:0] press, rel, held, rep;
  logic          anyp;

  always #5 clk = ~clk;

  button_event_gen #(.BUTTON_COUNT(BC), .HOLD_COUNTER_WIDTH(W)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_buttons(btn),
    .i_hold_delay(hold),
    .i_repeat_period(period),
    .o_press(press),
    .o_release(rel),
    .o_held(held),
    .o_repeat(rep),
    .o_any_press(anyp)
  );

  typedef struct packed {
    int          cyc;
    logic [4:0]  press;
    logic [4:0]  rel;
    logic [4:0]  rep;
    logic [4:0]  held;
    logic        anyp;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  logic [BC-1:0] held_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with a pulse or a change of the held level becomes one event.
  always @(negedge clk) begin
    if (!rst && (press != 0 || rel != 0 || rep != 0 || anyp || held != held_prev)) begin
      ev_t ev;
      ev.cyc = cyc; ev.press = press; ev.rel = rel; ev.rep = rep; ev.held = held; ev.anyp = anyp;
      obs_q.push_back(ev);
    end
    held_prev = held;
  end

  function automatic void push_exp(int c, logic [4:0] p, logic [4:0] r, logic [4:0] rp, logic [4:0] h, logic a);
    ev_t ev;
    ev.cyc = c; ev.press = p; ev.rel = r; ev.rep = rp; ev.held = h; ev.anyp = a;
    exp_q.push_back(ev);
  endfunction

  function automatic string fmt(ev_t ev);
    return $sformatf("cyc=%0d press=%b release=%b repeat=%b held=%b any=%b",
                     ev.cyc, ev.press, ev.rel, ev.rep, ev.held, ev.anyp);
  endfunction

  task automatic test_reset;
    btn = 5'b11111;
    hold = 8'd4;
    period = 8'd3;
    repeat (3) @(negedge clk);
    total++;
    if ({press, rel, held, rep, anyp} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs: got press=%b release=%b held=%b repeat=%b any=%b expected all 0",
               press, rel, held, rep, anyp);
    end
    btn = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (obs_q.size() !== 0) begin
      bad++;
      $display("FAIL reset_idle: got %0d events expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_short_press;
    int t0;
    ev_t e, o;
    @(negedge clk);
    hold = 8'd4; period = 8'd3; btn = 5'b00001; t0 = cyc;
    push_exp(t0 + 1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    push_exp(t0 + 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    push_exp(t0 + 4, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 1'b0);
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL short_press: got no event expected %s", fmt(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL short_press: got %s expected %s", fmt(o), fmt(e)); end
      end
    end
    total++;
    if (obs_q.size() !== 0) begin
      bad++; $display("FAIL short_press_extra: got %0d extra events expected 0 (%s)", obs_q.size(), fmt(obs_q[0]));
      obs_q.delete();
    end
  endtask

  task automatic test_hold_repeat;
    int t0;
    ev_t e, o;
    @(negedge clk);
    hold = 8'd4; period = 8'd3; btn = 5'b00010; t0 = cyc;
    push_exp(t0 + 1, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    push_exp(t0 + 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    push_exp(t0 + 5, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 1'b0);
    if (AR) begin
      for (int k = 8; k <= 20; k += 3)
        push_exp(t0 + k, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 1'b0);
    end
    push_exp(t0 + 21, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 1'b0);
    repeat (20) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL hold_repeat: got no event expected %s", fmt(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL hold_repeat: got %s expected %s", fmt(o), fmt(e)); end
      end
    end
    total++;
    if (obs_q.size() !== 0) begin
      bad++; $display("FAIL hold_repeat_extra: got %0d extra events expected 0 (%s)", obs_q.size(), fmt(obs_q[0]));
      obs_q.delete();
    end
  endtask

  task automatic test_priority;
    int t0;
    ev_t e, o;
    // Release lands on the hold terminal count: no HELD entry.
    @(negedge clk);
    hold = 8'd4; period = 8'd0; btn = 5'b00100; t0 = cyc;
    push_exp(t0 + 1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    push_exp(t0 + 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    push_exp(t0 + 5, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 1'b0);
    repeat (4) @(negedge clk);
    btn = '0;
    repeat (4) @(negedge clk);
    // Release lands on the repeat terminal count: no repeat pulse.
    hold = 8'd2; period = 8'd3; btn = 5'b01000; t0 = cyc;
    push_exp(t0 + 1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    push_exp(t0 + 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    push_exp(t0 + 3, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 1'b0);
    push_exp(t0 + 6, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 1'b0);
    repeat (5) @(negedge clk);
    btn = '0;
    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL priority: got no event expected %s", fmt(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL priority: got %s expected %s", fmt(o), fmt(e)); end
      end
    end
    total++;
    if (obs_q.size() !== 0) begin
      bad++; $display("FAIL priority_extra: got %0d extra events expected 0 (%s)", obs_q.size(), fmt(obs_q[0]));
      obs_q.delete();
    end
  endtask

  task automatic test_simultaneous;
    int t0;
    ev_t e, o;
    @(negedge clk);
    hold = 8'd0; period = 8'd3; btn = 5'b10001; t0 = cyc;
    push_exp(t0 + 1, 5'b10001, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    push_exp(t0 + 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    push_exp(t0 + 3, 5'b00000, 5'b10001, 5'b00000, 5'b00000, 1'b0);
    repeat (2) @(negedge clk);
    btn = '0;
    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL simultaneous: got no event expected %s", fmt(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL simultaneous: got %s expected %s", fmt(o), fmt(e)); end
      end
    end
    total++;
    if (obs_q.size() !== 0) begin
      bad++; $display("FAIL simultaneous_extra: got %0d extra events expected 0 (%s)", obs_q.size(), fmt(obs_q[0]));
      obs_q.delete();
    end
  endtask

  // Long press with hold disabled, then a small hold delay: a saturated counter never matches it.
  task automatic test_no_hold_saturate;
    int t0;
    ev_t e, o;
    @(negedge clk);
    hold = 8'd0; period = 8'd1; btn = 5'b01000; t0 = cyc;
    push_exp(t0 + 1, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    push_exp(t0 + 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    push_exp(t0 + 287, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 1'b0);
    repeat ((1 << W) + 10) @(negedge clk);
    hold = 8'd5;
    repeat (20) @(negedge clk);
    btn = '0;
    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL no_hold: got no event expected %s", fmt(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL no_hold: got %s expected %s", fmt(o), fmt(e)); end
      end
    end
    total++;
    if (obs_q.size() !== 0) begin
      bad++; $display("FAIL no_hold_extra: got %0d extra events expected 0 (%s)", obs_q.size(), fmt(obs_q[0]));
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_held;
    int t0, tr;
    ev_t e, o;
    @(negedge clk);
    hold = 8'd4; period = 8'd0; btn = 5'b00100; t0 = cyc;
    push_exp(t0 + 1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    push_exp(t0 + 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    push_exp(t0 + 5, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0);
    repeat (7) @(negedge clk);
    total++;
    if (held !== 5'b00100) begin
      bad++; $display("FAIL mid_held_before_reset: got held=%b expected 00100", held);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({press, rel, held, rep, anyp} !== 21'd0) begin
      bad++;
      $display("FAIL async_reset: got press=%b release=%b held=%b repeat=%b any=%b expected all 0",
               press, rel, held, rep, anyp);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; tr = cyc;
    push_exp(tr + 1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    push_exp(tr + 2, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    push_exp(tr + 5, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 1'b0);
    push_exp(tr + 8, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 1'b0);
    repeat (7) @(negedge clk);
    btn = '0;
    repeat (6) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL reset_mid_held: got no event expected %s", fmt(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL reset_mid_held: got %s expected %s", fmt(o), fmt(e)); end
      end
    end
    total++;
    if (obs_q.size() !== 0) begin
      bad++; $display("FAIL reset_mid_held_extra: got %0d extra events expected 0 (%s)", obs_q.size(), fmt(obs_q[0]));
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_hold_repeat();
    test_priority();
    test_simultaneous();
    test_no_hold_saturate();
    test_reset_mid_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
